// File: rtl/pe_chain_driver.sv
// Weight loader, sample streamer and result FIFO for a linear systolic PE chain.
// Define PE_DRV_BIAS_EN to load a bias word after the weights and drive it on PE_SUMIN in RUN.
module pe_chain_driver #(
  parameter int unsigned N      = 4,
  parameter int unsigned LAT    = 9,
  parameter int unsigned RDEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        W_VALID,
  output logic        W_READY,
  input  logic [17:0] W_DATA,
  input  logic        S_VALID,
  output logic        S_READY,
  input  logic [17:0] S_DATA,
  output logic        R_VALID,
  input  logic        R_READY,
  output logic [17:0] R_DATA,
  output logic [17:0] PE_DIN,
  output logic        PE_WE,
  output logic [17:0] PE_SUMIN,
  input  logic [17:0] PE_SUMO
);

  localparam int unsigned DW = 18;
  localparam int unsigned AW = $clog2(RDEPTH);
  localparam int unsigned CW = AW + 1;
`ifdef PE_DRV_BIAS_EN
  localparam int unsigned NW = N + 1;
`else
  localparam int unsigned NW = N;
`endif
  localparam int unsigned WCW = $clog2(NW + 1);
  localparam int unsigned FCW = $clog2(LAT + 1);

  typedef enum logic [2:0] {StLoad, StCommit, StFlush, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic [LAT-1:0]   vpipe_q, vpipe_d;
  logic [DW-1:0]    pe_din_q, pe_din_d;
  logic             pe_we_q, pe_we_d;
  logic [DW-1:0]    mem_q [RDEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DW-1:0]    r_data_q, r_data_d;
  logic             w_acc, s_acc, push, pop;
  logic [31:0]      pending;
`ifdef PE_DRV_BIAS_EN
  logic [DW-1:0]    bias_q, bias_d;
  logic [DW-1:0]    pe_sumin_q, pe_sumin_d;
`endif

  // Every sample still in the pipe owns a FIFO slot, so a push can never overflow.
  always_comb begin
    pending = 32'(count_q) + 32'($countones(vpipe_q));
    W_READY = RST && (state_q == StLoad);
    S_READY = RST && (state_q == StRun) && (pending < RDEPTH) && !W_VALID;
    R_VALID = (count_q != '0);
    w_acc   = W_VALID && W_READY;
    s_acc   = S_VALID && S_READY;
    push    = vpipe_q[LAT-1];
    pop     = R_VALID && R_READY;
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    fcnt_d   = fcnt_q;
    pe_din_d = pe_din_q;
    pe_we_d  = 1'b0;
    vpipe_d  = vpipe_q << 1;
    vpipe_d[0] = s_acc;
`ifdef PE_DRV_BIAS_EN
    bias_d   = bias_q;
`endif
    unique case (state_q)
      StLoad: begin
        if (w_acc) begin
`ifdef PE_DRV_BIAS_EN
          if (wcnt_q < WCW'(N)) pe_din_d = W_DATA;
          else                  bias_d   = W_DATA;
`else
          pe_din_d = W_DATA;
`endif
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == WCW'(NW - 1)) begin
            state_d = StCommit;
            wcnt_d  = '0;
            pe_we_d = 1'b1;
          end
        end
      end
      StCommit: begin
        state_d  = StFlush;
        fcnt_d   = '0;
        pe_din_d = '0;
      end
      StFlush: begin
        pe_din_d = '0;
        if (fcnt_q == FCW'(LAT - 1)) state_d = StRun;
        else                         fcnt_d  = fcnt_q + 1'b1;
      end
      StRun: begin
        pe_din_d = s_acc ? S_DATA : '0;
        if (W_VALID) state_d = StDrain;
      end
      StDrain: begin
        pe_din_d = '0;
        if (vpipe_q == '0) state_d = StLoad;
      end
      default: state_d = StLoad;
    endcase
`ifdef PE_DRV_BIAS_EN
    pe_sumin_d = (state_d == StRun) ? bias_d : '0;
`endif
  end

  // R_DATA is a registered copy of the head that tracks this cycle's push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    r_data_d = r_data_q;
    if (pop) begin
      if (count_q > CW'(1))   r_data_d = mem_q[rd_ptr_d];
      else if (push)          r_data_d = PE_SUMO;
    end else if (count_q == '0 && push) begin
      r_data_d = PE_SUMO;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= StLoad;
      wcnt_q   <= '0;
      fcnt_q   <= '0;
      vpipe_q  <= '0;
      pe_din_q <= '0;
      pe_we_q  <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      r_data_q <= '0;
`ifdef PE_DRV_BIAS_EN
      bias_q     <= '0;
      pe_sumin_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      fcnt_q   <= fcnt_d;
      vpipe_q  <= vpipe_d;
      pe_din_q <= pe_din_d;
      pe_we_q  <= pe_we_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      r_data_q <= r_data_d;
`ifdef PE_DRV_BIAS_EN
      bias_q     <= bias_d;
      pe_sumin_q <= pe_sumin_d;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST && push) mem_q[wr_ptr_q] <= PE_SUMO;
  end

  assign PE_DIN = pe_din_q;
  assign PE_WE  = pe_we_q;
  assign R_DATA = r_data_q;
`ifdef PE_DRV_BIAS_EN
  assign PE_SUMIN = pe_sumin_q;
`else
  assign PE_SUMIN = '0;
`endif

endmodule
